mlp_layer_sequencer: RTL and testbench

Controller that runs a multi-layer perceptron inference on the shared matrix-vector engine (`y = M·x + b`). It captures an input vector, selects each layer's weight/bias bank, arms and waits on the engine, then requantizes each result (ReLU, shift, saturate) into the next layer's input. It sits between the host-side start/done handshake and a single engine instance, which it owns exclusively.

---
 rtl/mlp_layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: runs a multi-layer perceptron inference on one shared
// matrix-vector engine (y = M*x + b). Each layer arms the engine, waits for
// its completion flag, then requantizes the result (ReLU, arithmetic shift,
// saturate) into the next layer's activation vector. The final layer's raw
// accumulator values are published on result.
//
// Handshake: start is sampled only while the sequencer is not busy (IDLE,
// DONE or ERR states); an accepted start raises busy on the same edge and
// clears done/err. busy falls on the edge that enters DONE (done rises on
// that same edge, with result already valid) or ERR (err rises). done and
// err are held until the next accepted start or reset. start while busy is
// ignored.
module mlp_layer_sequencer #(
    parameter int bits       = 8,
    parameter int outbits    = 24,
    parameter int dim        = 10,
    parameter int num_layers = 3,
    parameter int shift      = 4,
    parameter int timeout    = 1023,
    localparam int lw        = (num_layers > 1) ? $clog2(num_layers) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [bits-1:0]    x_in [0:dim-1],
    input  logic signed [outbits-1:0] eng_y [0:dim-1],
    input  logic                      eng_done,
    output logic                      eng_reset,
    output logic signed [bits-1:0]    eng_x [0:dim-1],
    output logic [lw-1:0]             layer,
    output logic signed [outbits-1:0] result [0:dim-1],
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                dbg_state
);

    localparam int cw = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [cw-1:0] cnt_max = cw'(timeout);
    localparam logic [lw-1:0] last_layer = lw'(num_layers - 1);
    localparam logic signed [outbits-1:0] max_act = outbits'((1 << (bits - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_REQ  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [cw-1:0]   cnt;

    assign dbg_state = state;

    // ReLU, arithmetic right shift, then clamp to the largest positive activation.
    function automatic logic signed [bits-1:0] requant(input logic signed [outbits-1:0] v);
        logic signed [outbits-1:0] s;
        s = v >>> shift;
        if (v[outbits-1])
            return '0;
        else if (s > max_act)
            return max_act[bits-1:0];
        else
            return s[bits-1:0];
    endfunction

    // State register; reset returns to IDLE on the next edge.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state decode and engine reset; the engine only runs in RUN and REQ,
    // so eng_reset pulses for exactly the ARM cycle between layers.
    always_comb begin
        state_next = state;
        eng_reset  = 1'b1;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start)
                    state_next = S_ARM;
            end
            S_ARM: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                eng_reset = 1'b0;
                if (eng_done)
                    state_next = S_REQ;
                else if (cnt == cnt_max)
                    state_next = S_ERR;
            end
            S_REQ: begin
                eng_reset  = 1'b0;
                state_next = (layer == last_layer) ? S_DONE : S_ARM;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and status registers: capture, timeout counter, requantize, publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < dim; i++) begin
                eng_x[i]  <= '0;
                result[i] <= '0;
            end
            layer <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        eng_x <= x_in;
                        layer <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                S_ARM: begin
                    cnt <= '0;
                end
                S_RUN: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (!eng_done) begin
                        if (cnt == cnt_max) begin
                            busy <= 1'b0;
                            done <= 1'b0;
                            err  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (layer == last_layer) begin
                        result <= eng_y;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        for (int i = 0; i < dim; i++)
                            eng_x[i] <= requant(eng_y[i]);
                        layer <= layer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Testbench for mlp_layer_sequencer: a behavioural engine stub with
// configurable latency, randomized weights/inputs, and a reference model that
// computes every layer's expected activation vector and the final result.
module tb_mlp_layer_sequencer;

    localparam int BITS  = 8;
    localparam int OB    = 24;
    localparam int DIM   = 4;
    localparam int NL    = 3;
    localparam int SHIFT = 4;
    localparam int TO    = 40;
    localparam int LW    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    logic signed [BITS-1:0] x_in   [0:DIM-1];
    logic signed [OB-1:0]   eng_y  [0:DIM-1];
    logic                   eng_done;
    logic                   eng_reset;
    logic signed [BITS-1:0] eng_x  [0:DIM-1];
    logic [LW-1:0]          layer;
    logic signed [OB-1:0]   result [0:DIM-1];
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [2:0]             dbg_state;

    mlp_layer_sequencer #(
        .bits(BITS), .outbits(OB), .dim(DIM), .num_layers(NL),
        .shift(SHIFT), .timeout(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in),
        .eng_y(eng_y), .eng_done(eng_done), .eng_reset(eng_reset),
        .eng_x(eng_x), .layer(layer), .result(result), .busy(busy),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- engine stub ----------------
    int w  [NL][DIM][DIM];
    int bv [NL][DIM];
    int lat;
    bit hang;
    int ecnt;

    always @(posedge clk) begin
        if (eng_reset)
            ecnt <= 0;
        else
            ecnt <= ecnt + 1;
    end

    assign eng_done = !hang && !eng_reset && (ecnt >= lat - 1);

    always_comb begin
        int li;
        int acc;
        li  = (int'(layer) < NL) ? int'(layer) : 0;
        acc = 0;
        for (int i = 0; i < DIM; i++) begin
            acc = bv[li][i];
            for (int j = 0; j < DIM; j++)
                acc = acc + w[li][i][j] * int'(eng_x[j]);
            eng_y[i] = OB'(acc);
        end
    end

    // ---------------- scoreboard / model ----------------
    int mx   [NL][DIM];
    int mres [DIM];
    int last_res [DIM];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Layer-by-layer reference: y = M*x + b, ReLU / divide by 2^SHIFT / clamp to 127.
    task automatic model(input int xv[DIM]);
        int cur [DIM];
        int y   [DIM];
        int q;
        cur = xv;
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < DIM; i++) mx[l][i] = cur[i];
            for (int i = 0; i < DIM; i++) begin
                y[i] = bv[l][i];
                for (int j = 0; j < DIM; j++) y[i] += w[l][i][j] * cur[j];
            end
            if (l == NL - 1) begin
                mres = y;
            end else begin
                for (int i = 0; i < DIM; i++) begin
                    if (y[i] < 0) q = 0;
                    else q = y[i] / (2 ** SHIFT);
                    cur[i] = (q > 127) ? 127 : q;
                end
            end
        end
    endtask

    task automatic rand_weights();
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < DIM; i++) begin
                bv[l][i] = int'($urandom_range(0, 1000)) - 500;
                for (int j = 0; j < DIM; j++)
                    w[l][i][j] = int'($urandom_range(0, 40)) - 20;
            end
    endtask

    task automatic rand_vec(output int xv[DIM]);
        for (int i = 0; i < DIM; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    // ---------------- driver tasks ----------------
    task automatic begin_run(input int xv[DIM], input bit hold);
        @(negedge clk);
        for (int i = 0; i < DIM; i++) x_in[i] = BITS'(xv[i]);
        start = 1'b1;
        model(xv);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        // later x_in changes must not reach the datapath
        for (int i = 0; i < DIM; i++) x_in[i] = BITS'($urandom_range(0, 255));
    endtask

    // Follows one inference from its ARM cycle until busy drops.
    task automatic watch(input int exp_cycles, input int exp_arms, input bit exp_err);
        int cyc;
        int arms;
        cyc  = 0;
        arms = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 3000) begin
            if (eng_reset === 1'b1) begin
                if (arms < NL) begin
                    check($sformatf("arm%0d_layer", arms), layer, arms);
                    for (int i = 0; i < DIM; i++)
                        check($sformatf("arm%0d_x%0d", arms, i), eng_x[i], mx[arms][i]);
                end
                arms++;
            end
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles", cyc, exp_cycles);
        check("arm_count", arms, exp_arms);
        check("err", err, exp_err);
        check("done", done, !exp_err);
        check("eng_reset_after", eng_reset, 1);
        if (!exp_err) last_res = mres;
        for (int i = 0; i < DIM; i++)
            check($sformatf("result%0d", i), result[i], last_res[i]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_layer"}, layer, 0);
        check({tag, "_eng_reset"}, eng_reset, 1);
        for (int i = 0; i < DIM; i++) begin
            check($sformatf("%s_eng_x%0d", tag, i), eng_x[i], 0);
            check($sformatf("%s_result%0d", tag, i), result[i], 0);
        end
    endtask

    function automatic int ok_cycles(input int l);
        return 2 * NL + NL * l;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int xv [DIM];
        int x2 [DIM];
        bit found;

        reset = 1'b1;
        start = 1'b0;
        hang  = 1'b0;
        lat   = 5;
        for (int i = 0; i < DIM; i++) begin
            x_in[i]     = '0;
            last_res[i] = 0;
        end
        rand_weights();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Directed requantization: layer 0 outputs {1000, 5000, -20, 15}.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) w[0][i][j] = 0;
        bv[0][0] = 1000; bv[0][1] = 5000; bv[0][2] = -20; bv[0][3] = 15;
        lat = DIM * (DIM + 2);
        rand_vec(xv);
        begin_run(xv, 1'b0);
        watch(ok_cycles(lat), NL, 1'b0);

        // Random inferences with random engine latency.
        for (int t = 0; t < 6; t++) begin
            rand_weights();
            rand_vec(xv);
            lat = int'($urandom_range(1, TO + 1));
            begin_run(xv, 1'b0);
            watch(ok_cycles(lat), NL, 1'b0);
        end

        // Completion on the very cycle the timeout would fire.
        rand_weights();
        rand_vec(xv);
        lat = TO + 1;
        begin_run(xv, 1'b0);
        watch(ok_cycles(lat), NL, 1'b0);

        // Engine never finishes: timeout after TO+1 RUN cycles.
        hang = 1'b1;
        rand_vec(xv);
        begin_run(xv, 1'b0);
        watch(1 + TO + 1, 1, 1'b1);
        hang = 1'b0;

        // A start from ERR clears err and runs normally.
        rand_vec(xv);
        lat = 7;
        begin_run(xv, 1'b0);
        watch(ok_cycles(lat), NL, 1'b0);

        // start held high: ignored while busy, restarts on the first DONE cycle.
        rand_weights();
        rand_vec(xv);
        lat = 3;
        begin_run(xv, 1'b1);
        watch(ok_cycles(lat), NL, 1'b0);
        rand_vec(x2);
        for (int i = 0; i < DIM; i++) x_in[i] = BITS'(x2[i]);
        model(x2);
        watch(ok_cycles(lat), NL, 1'b0);
        start = 1'b0;

        // Reset during layer 1 RUN.
        rand_weights();
        rand_vec(xv);
        lat = 20;
        begin_run(xv, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (layer == 2'd1 && eng_reset == 1'b0 && busy == 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_layer1_run", found, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DIM; i++) last_res[i] = 0;

        // Normal inference after the mid-run reset.
        rand_vec(xv);
        lat = 11;
        begin_run(xv, 1'b0);
        watch(ok_cycles(lat), NL, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
